mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses issued from the MEM stage against a variable-latency data memory using a req/ready handshake.
- Freezes the upstream pipeline registers while an access is outstanding and forces a bubble into the MEM/WB pipeline register.
- Returns captured load data (ReadDataM) to the MEM/WB register once the access completes.
- Detects misaligned addresses and access timeouts, and flags both.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for dmem_ready before the access is aborted (1..255).

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- MemReadM  in  1  MEM-stage instruction is a load.
- MemWriteM  in  1  MEM-stage instruction is a store.
- ALUOutM  in  32  byte address of the access.
- WriteDataM  in  32  store data.
- dmem_ready  in  1  memory completes the current request this cycle.
- dmem_rdata  in  32  load data, valid when dmem_ready=1.
- dmem_req  out  1  request to memory (registered).
- dmem_we  out  1  1=write, 0=read (registered).
- dmem_addr  out  32  word-aligned request address (registered).
- dmem_wdata  out  32  request store data (registered).
- ReadDataM  out  32  completed load data, to the MEM/WB register.
- StallM  out  1  hold the PC and the F/D, D/E and E/M registers.
- BubbleW  out  1  MEM/WB register loads a nop (RegWrite=0, MemtoReg=0).
- mem_fault  out  1  sticky error flag (misaligned access or timeout).

Behaviour:
- Reset (async, RST=1): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; ReadDataM=0; timeout counter=0; mem_fault=0. StallM and BubbleW evaluate to 0.
- Definitions: access = MemReadM|MemWriteM; misaligned = ALUOutM[1:0]!=0.
- StallM is combinational: StallM = (IDLE & access & !misaligned) | REQ. BubbleW = StallM.
- States:
  - IDLE:
    - access & !misaligned: next=REQ. Latch dmem_addr=ALUOutM, dmem_wdata=WriteDataM, dmem_we=MemWriteM; set dmem_req=1; clear the counter.
    - access & misaligned: no request; stay IDLE; mem_fault<=1; ReadDataM<=0; no stall, so the instruction advances.
    - otherwise: stay IDLE.
  - REQ: dmem_req=1; address, write data and we held stable.
    - dmem_ready=1: ReadDataM<=dmem_rdata if a read, unchanged if a write; dmem_req<=0; next=DONE.
    - else, counter==TIMEOUT_CYCLES-1: dmem_req<=0; mem_fault<=1; ReadDataM<=0; next=DONE.
    - else: counter increments.
  - DONE: StallM=0 and BubbleW=0 for exactly 1 cycle, so the access instruction moves into the MEM/WB register with ReadDataM. MemReadM/MemWriteM are ignored in this state (same instruction). next=IDLE unconditionally.
- Latency: a zero-wait memory (ready in the first REQ cycle) gives 2 stall cycles (IDLE-detect, REQ) and then DONE. Each extra wait cycle adds 1 stall cycle.
- Back-to-back accesses: a new access is first sampled in IDLE, the cycle after DONE. There is no overlap of requests.
- dmem_ready outside REQ is ignored.
- mem_fault is cleared only by RST.
- RST asserted mid-REQ: dmem_req drops immediately (asynchronous) and the in-flight access is abandoned.
- Counter width is 8 bits; no wrap is possible because TIMEOUT_CYCLES<=255.

Test Plan:
- Reset: RST=1 mid-REQ -> dmem_req=0, StallM=0 and ReadDataM=0 immediately; state IDLE after release.
- Zero-wait load: MemReadM=1, ALUOutM=0x100, dmem_ready=1 on the first REQ cycle with rdata=0xDEADBEEF -> dmem_req high 1 cycle with addr=0x100, we=0; StallM/BubbleW high 2 cycles; ReadDataM=0xDEADBEEF with StallM=0 in DONE.
- Waited store: MemWriteM=1, ALUOutM=0x204, WriteDataM=0x12345678, ready after 3 REQ cycles -> dmem_we=1, dmem_wdata=0x12345678 stable throughout; StallM high 4 cycles; ReadDataM unchanged.
- Misaligned: MemReadM=1, ALUOutM=0x102 -> dmem_req never asserts, StallM=0, mem_fault=1 next cycle and stays 1 after further good accesses.
- Timeout with TIMEOUT_CYCLES=4, dmem_ready held 0 -> dmem_req high exactly 4 cycles then drops; mem_fault=1; DONE with ReadDataM=0; next access proceeds normally.
- Back-to-back loads to 0x10 then 0x14, zero-wait -> two distinct requests separated by DONE and IDLE cycles; MemReadM still high during DONE does not issue a third request.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage access controller.
// The controller uses the master modport; the pipeline/memory environment uses slave.
interface mem_access_ctrl_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        BubbleW;
    logic        mem_fault;

    // Handshake: a request is held (dmem_req, dmem_we, dmem_addr, dmem_wdata
    // stable) until the first cycle in which dmem_ready=1 while dmem_req=1;
    // that cycle completes it. dmem_ready is ignored whenever dmem_req=0.
    modport master (
        input  MemReadM, MemWriteM, ALUOutM, WriteDataM, dmem_ready, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, ReadDataM, StallM, BubbleW, mem_fault
    );

    modport slave (
        output MemReadM, MemWriteM, ALUOutM, WriteDataM, dmem_ready, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, ReadDataM, StallM, BubbleW, mem_fault
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: freezes the pipeline during a variable-latency
// access, returns load data, and flags misaligned accesses and timeouts (sticky).
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_access_ctrl_if.master     bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;

    logic access;
    logic misaligned;
    logic stall;

    assign access     = bus.MemReadM | bus.MemWriteM;
    assign misaligned = (bus.ALUOutM[1:0] != 2'b00);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = bus.MemWriteM;
                    addr_d  = {bus.ALUOutM[31:2], 2'b00};
                    wdata_d = bus.WriteDataM;
                    cnt_d   = 8'd0;
                end else if (access) begin
                    // Misaligned: no request and no stall; the instruction retires with zero data.
                    fault_d = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            S_REQ: begin
                if (bus.dmem_ready) begin
                    if (!we_q) begin
                        rdata_d = bus.dmem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    rdata_d = 32'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // The same instruction is still in MEM here, so its access bits are not re-sampled.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset forces the pipeline free immediately, even while the MEM-stage access bits are still high.
    assign stall = !RST && (((state_q == S_IDLE) && access && !misaligned) || (state_q == S_REQ));

    assign bus.StallM     = stall;
    assign bus.BubbleW    = stall;
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.ReadDataM  = rdata_q;
    assign bus.mem_fault  = fault_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl (TIMEOUT_CYCLES=4), plus a
// hand-written reset-during-request sequence.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK         (clk),
        .RST         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    localparam logic [1:0] SI = 2'd0, SR = 2'd1, SD = 2'd2;
    localparam logic [31:0] D = 32'hDEADBEEF, S = 32'h12345678, A = 32'hA5A50010;
    localparam logic [31:0] B = 32'h5A5A0014, C = 32'h11112222, F = 32'hCAFEF00D;

    // One record per clock: inputs for the cycle, then the outputs expected
    // mid-cycle (registered outputs reflect earlier edges, StallM reflects these inputs).
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [31:0] e_rdata;
        logic        e_fault;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[32];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rdy, input logic [31:0] rdata);
        bus.MemReadM   = rd;
        bus.MemWriteM  = wr;
        bus.ALUOutM    = addr;
        bus.WriteDataM = wdata;
        bus.dmem_ready = rdy;
        bus.dmem_rdata = rdata;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        chk("dmem_req",   idx, {31'd0, bus.dmem_req}, {31'd0, v.e_req});
        chk("dmem_we",    idx, {31'd0, bus.dmem_we},  {31'd0, v.e_we});
        chk("dmem_addr",  idx, bus.dmem_addr,  v.e_addr);
        chk("dmem_wdata", idx, bus.dmem_wdata, v.e_wdata);
        chk("StallM",     idx, {31'd0, bus.StallM},  {31'd0, v.e_stall});
        chk("BubbleW",    idx, {31'd0, bus.BubbleW}, {31'd0, v.e_stall});
        chk("ReadDataM",  idx, bus.ReadDataM, v.e_rdata);
        chk("mem_fault",  idx, {31'd0, bus.mem_fault}, {31'd0, v.e_fault});
        chk("state",      idx, {30'd0, dbg_state}, {30'd0, v.e_state});
    endtask

    initial begin
        //            rd wr addr       wdata rdy rdata          req we e_addr     e_wdata stall e_rdata flt state
        // zero-wait load; stray ready in DONE/IDLE ignored
        vecs[0]  = '{0, 0, 32'h0,     32'h0, 0, 32'h0,         0, 0, 32'h0,     32'h0, 0, 32'h0, 0, SI};
        vecs[1]  = '{1, 0, 32'h100,   32'h0, 0, 32'h0,         0, 0, 32'h0,     32'h0, 1, 32'h0, 0, SI};
        vecs[2]  = '{1, 0, 32'h100,   32'h0, 1, D,             1, 0, 32'h100,   32'h0, 1, 32'h0, 0, SR};
        vecs[3]  = '{1, 0, 32'h100,   32'h0, 1, 32'h0BAD0BAD,  0, 0, 32'h100,   32'h0, 0, D,     0, SD};
        vecs[4]  = '{0, 0, 32'h0,     32'h0, 1, 32'h0BAD0BAD,  0, 0, 32'h100,   32'h0, 0, D,     0, SI};
        // store, ready on the third REQ cycle
        vecs[5]  = '{0, 1, 32'h204,   S,     0, 32'h0,         0, 0, 32'h100,   32'h0, 1, D,     0, SI};
        vecs[6]  = '{0, 1, 32'h204,   S,     0, 32'h0,         1, 1, 32'h204,   S,     1, D,     0, SR};
        vecs[7]  = '{0, 1, 32'h204,   S,     0, 32'h0,         1, 1, 32'h204,   S,     1, D,     0, SR};
        vecs[8]  = '{0, 1, 32'h204,   S,     1, 32'hFFFFFFFF,  1, 1, 32'h204,   S,     1, D,     0, SR};
        vecs[9]  = '{0, 1, 32'h204,   S,     0, 32'h0,         0, 1, 32'h204,   S,     0, D,     0, SD};
        // back-to-back zero-wait loads; MemReadM held in the final DONE
        vecs[10] = '{1, 0, 32'h10,    32'h0, 0, 32'h0,         0, 1, 32'h204,   S,     1, D,     0, SI};
        vecs[11] = '{1, 0, 32'h10,    32'h0, 1, A,             1, 0, 32'h10,    32'h0, 1, D,     0, SR};
        vecs[12] = '{1, 0, 32'h10,    32'h0, 0, 32'h0,         0, 0, 32'h10,    32'h0, 0, A,     0, SD};
        vecs[13] = '{1, 0, 32'h14,    32'h0, 0, 32'h0,         0, 0, 32'h10,    32'h0, 1, A,     0, SI};
        vecs[14] = '{1, 0, 32'h14,    32'h0, 1, B,             1, 0, 32'h14,    32'h0, 1, A,     0, SR};
        vecs[15] = '{1, 0, 32'h14,    32'h0, 0, 32'h0,         0, 0, 32'h14,    32'h0, 0, B,     0, SD};
        vecs[16] = '{0, 0, 32'h0,     32'h0, 0, 32'h0,         0, 0, 32'h14,    32'h0, 0, B,     0, SI};
        // misaligned load, then a good load with the fault still set
        vecs[17] = '{1, 0, 32'h102,   32'h0, 0, 32'h0,         0, 0, 32'h14,    32'h0, 0, B,     0, SI};
        vecs[18] = '{0, 0, 32'h0,     32'h0, 0, 32'h0,         0, 0, 32'h14,    32'h0, 0, 32'h0, 1, SI};
        vecs[19] = '{1, 0, 32'h40,    32'h0, 0, 32'h0,         0, 0, 32'h14,    32'h0, 1, 32'h0, 1, SI};
        vecs[20] = '{1, 0, 32'h40,    32'h0, 1, C,             1, 0, 32'h40,    32'h0, 1, 32'h0, 1, SR};
        vecs[21] = '{0, 0, 32'h0,     32'h0, 0, 32'h0,         0, 0, 32'h40,    32'h0, 0, C,     1, SD};
        // timeout: four REQ cycles, then DONE with zero data
        vecs[22] = '{1, 0, 32'h300,   32'h0, 0, 32'h0,         0, 0, 32'h40,    32'h0, 1, C,     1, SI};
        vecs[23] = '{1, 0, 32'h300,   32'h0, 0, 32'h0,         1, 0, 32'h300,   32'h0, 1, C,     1, SR};
        vecs[24] = '{1, 0, 32'h300,   32'h0, 0, 32'h0,         1, 0, 32'h300,   32'h0, 1, C,     1, SR};
        vecs[25] = '{1, 0, 32'h300,   32'h0, 0, 32'h0,         1, 0, 32'h300,   32'h0, 1, C,     1, SR};
        vecs[26] = '{1, 0, 32'h300,   32'h0, 0, 32'h0,         1, 0, 32'h300,   32'h0, 1, C,     1, SR};
        vecs[27] = '{1, 0, 32'h300,   32'h0, 0, 32'h0,         0, 0, 32'h300,   32'h0, 0, 32'h0, 1, SD};
        // next access after the timeout
        vecs[28] = '{1, 0, 32'h20,    32'h0, 0, 32'h0,         0, 0, 32'h300,   32'h0, 1, 32'h0, 1, SI};
        vecs[29] = '{1, 0, 32'h20,    32'h0, 1, F,             1, 0, 32'h20,    32'h0, 1, 32'h0, 1, SR};
        vecs[30] = '{0, 0, 32'h0,     32'h0, 0, 32'h0,         0, 0, 32'h20,    32'h0, 0, F,     1, SD};
        vecs[31] = '{0, 0, 32'h0,     32'h0, 0, 32'h0,         0, 0, 32'h20,    32'h0, 0, F,     1, SI};

        // clock/reset
        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        check_vec(-1, vecs[0]);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, vecs[i].rdata);
            #1;
            check_vec(i, vecs[i]);
        end

        // Reset asserted between edges while a request is outstanding
        @(negedge clk);
        drive(1, 0, 32'h80, 32'h0, 0, 32'h0);
        @(negedge clk);
        #1;
        chk("rst_pre_req",   100, {31'd0, bus.dmem_req}, 32'd1);
        chk("rst_pre_state", 100, {30'd0, dbg_state}, {30'd0, SR});
        #1;
        rst = 1'b1;
        #1;
        chk("rst_req",   101, {31'd0, bus.dmem_req},  32'd0);
        chk("rst_stall", 101, {31'd0, bus.StallM},    32'd0);
        chk("rst_bubble",101, {31'd0, bus.BubbleW},   32'd0);
        chk("rst_rdata", 101, bus.ReadDataM,          32'd0);
        chk("rst_fault", 101, {31'd0, bus.mem_fault}, 32'd0);
        chk("rst_state", 101, {30'd0, dbg_state},     {30'd0, SI});
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_state", 102, {30'd0, dbg_state},  {30'd0, SI});
        chk("post_rst_req",   102, {31'd0, bus.dmem_req}, 32'd0);

        // A fresh zero-wait load works normally after the abandoned access
        @(negedge clk);
        drive(1, 0, 32'h8, 32'h0, 0, 32'h0);
        #1;
        chk("post_rst_stall", 103, {31'd0, bus.StallM}, 32'd1);
        @(negedge clk);
        drive(1, 0, 32'h8, 32'h0, 1, 32'h00000077);
        #1;
        chk("post_rst_req2",  104, {31'd0, bus.dmem_req}, 32'd1);
        chk("post_rst_addr",  104, bus.dmem_addr, 32'h8);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        chk("post_rst_rdata", 105, bus.ReadDataM, 32'h00000077);
        chk("post_rst_done",  105, {30'd0, dbg_state}, {30'd0, SD});
        chk("post_rst_fault", 105, {31'd0, bus.mem_fault}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
